decoder_pipe_host: RTL and testbench

- Parametrised successor of the 4-to-16 decoder host.
- Converts an ENC_W-bit code into a 2**SEL_W-bit one-hot or thermometer word.
- Uses a valid/ready input handshake and a 3-state decode FSM. Results are buffered in an output FIFO, each tagged with a wrapping sequence number.
- Sits between a code producer (stimulus/LFSR block) and any downstream consumer with backpressure.

---
 rtl/decoder_pipe_pkg.sv | 27 ++
 rtl/decoder_pipe_host_fifo.sv | 59 +++++
 rtl/decoder_pipe_host.sv | 154 +++++++++++++++
 tb/tb_decoder_pipe_host.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pipe_pkg.sv
// Shared types and decode helper for the decoder_pipe_host slice.
package decoder_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WRITE  = 2'd2
  } state_e;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_THERM  = 1'b1;

  // Widest decoded word the helper can produce; callers keep the low OUT_W bits.
  localparam int unsigned DEC_MAX_W = 256;

  function automatic logic [DEC_MAX_W-1:0] decode_word(input logic [31:0] code,
                                                        input logic        mode);
    logic [DEC_MAX_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
      if (mode == MODE_THERM) w[i] = (32'(i) <= code);
      else                    w[i] = (32'(i) == code);
    end
    return w;
  endfunction

endpackage

// File: rtl/decoder_pipe_host_fifo.sv
// Shift-register FIFO: entry 0 is the registered head, unused slots are kept at zero.
module decoder_pipe_fifo #(
  parameter int unsigned W     = 30,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    do_pop, do_push;
  logic [AW-1:0]           wr_idx;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_idx  = AW'(count_q) - AW'(do_pop);
    if (flush) begin
      mem_d   = '0;
      count_d = '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        mem_d[DEPTH-1] = '0;
      end
      if (do_push) mem_d[wr_idx] = din;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[0];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/decoder_pipe_host.sv
// Code-to-one-hot/thermometer decoder with handshake, 3-state FSM and tagged output FIFO.
// Optional DECODER_PIPE_PARITY_EN adds out_par, the even parity of each stored entry.
module decoder_pipe_host import decoder_pipe_pkg::*; #(
  parameter int unsigned ENC_W    = 8,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 13,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  pon_rst_i,
  input  logic [ENC_W-1:0]      encoded_input,
  input  logic                  mode_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush_i,
  output logic [2**SEL_W-1:0]   out_data,
  output logic                  out_err,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERRCNT_W-1:0]   err_count
`ifdef DECODER_PIPE_PARITY_EN
  ,
  output logic                  out_par
`endif
);

  localparam int unsigned OUT_W = 2**SEL_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMP_W = (ENC_W > SEL_W + 1) ? ENC_W : SEL_W + 1;
`ifdef DECODER_PIPE_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned ENTRY_W = OUT_W + 1 + TAG_W + PW;

  state_e               state_q, state_d;
  logic [ENC_W-1:0]     code_q, code_d;
  logic                 mode_q, mode_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [TAG_W-1:0]     tag_cnt_q, tag_cnt_d;
  logic [OUT_W-1:0]     res_q, res_d;
  logic                 res_err_q, res_err_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                 live_q, live_d;

  logic                 accept_c, push_c, code_oor_c;
  logic [ENTRY_W-1:0]   fifo_din, fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;

  // live_q keeps in_ready low while reset is held and for the first cycle after.
  assign in_ready   = live_q && (state_q == IDLE) && (fifo_count < CNT_W'(DEPTH)) && !flush_i;
  assign accept_c   = in_valid && in_ready;
  assign code_oor_c = CMP_W'(code_q) >= CMP_W'(OUT_W);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    mode_d    = mode_q;
    tag_d     = tag_q;
    tag_cnt_d = tag_cnt_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    err_cnt_d = err_cnt_q;
    live_d    = 1'b1;
    push_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          code_d    = encoded_input;
          mode_d    = mode_i;
          tag_d     = tag_cnt_q;
          tag_cnt_d = tag_cnt_q + TAG_W'(1);
          state_d   = DECODE;
        end
      end
      DECODE: begin
        if (code_oor_c) begin
          res_d     = '0;
          res_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end else begin
          res_d     = OUT_W'(decode_word(32'(code_q), mode_q));
          res_err_d = 1'b0;
        end
        state_d = WRITE;
      end
      WRITE: begin
        push_c  = !fifo_full;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge pon_rst_i) begin
    if (pon_rst_i) begin
      state_q   <= IDLE;
      code_q    <= '0;
      mode_q    <= MODE_ONEHOT;
      tag_q     <= '0;
      tag_cnt_q <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      err_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      mode_q    <= mode_d;
      tag_q     <= tag_d;
      tag_cnt_q <= tag_cnt_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      err_cnt_q <= err_cnt_d;
      live_q    <= live_d;
    end
  end

`ifdef DECODER_PIPE_PARITY_EN
  assign fifo_din = {res_q, res_err_q, tag_q, ^{res_q, res_err_q, tag_q}};
  assign out_par  = fifo_dout[0];
`else
  assign fifo_din = {res_q, res_err_q, tag_q};
`endif

  decoder_pipe_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (pon_rst_i),
    .push  (push_c),
    .pop   (out_ready),
    .flush (flush_i),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Empty FIFO slots hold zero, so the head fields read zero when nothing is queued.
  assign out_data  = fifo_dout[ENTRY_W-1 -: OUT_W];
  assign out_err   = fifo_dout[TAG_W+PW];
  assign out_tag   = fifo_dout[TAG_W-1+PW : PW];
  assign out_valid = !fifo_empty;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_decoder_pipe_host.sv
// Scoreboard bench for decoder_pipe_host: stimulus queues expectations, a monitor pops on each handshake.
module tb_decoder_pipe_host;

  localparam int unsigned ENC_W    = 8;
  localparam int unsigned TAG_W    = 13;
  localparam int unsigned ERRCNT_W = 8;

  logic                clk = 1'b0;
  logic                pon_rst_i = 1'b0;
  logic [ENC_W-1:0]    encoded_input;
  logic                mode_i;
  logic                in_valid;
  logic                in_ready;
  logic                flush_i;
  logic [15:0]         out_data;
  logic                out_err;
  logic [TAG_W-1:0]    out_tag;
  logic                out_valid;
  logic                out_ready;
  logic [ERRCNT_W-1:0] err_count;
`ifdef DECODER_PIPE_PARITY_EN
  logic                out_par;
`endif

  decoder_pipe_host u_dut (
    .clk           (clk),
    .pon_rst_i     (pon_rst_i),
    .encoded_input (encoded_input),
    .mode_i        (mode_i),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush_i       (flush_i),
    .out_data      (out_data),
    .out_err       (out_err),
    .out_tag       (out_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_count     (err_count)
`ifdef DECODER_PIPE_PARITY_EN
    ,
    .out_par       (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      data;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [TAG_W-1:0] exp_tag = '0;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model(input int code, input bit mode);
    if (code >= 16) return 16'h0000;
    if (mode) return 16'((32'd2 << code) - 32'd1);
    return 16'(32'd1 << code);
  endfunction

  // Present a code until accepted or the budget runs out; expectations are queued on accept.
  task automatic send(input int code, input bit mode, input int budget, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    encoded_input = ENC_W'(code);
    mode_i        = mode;
    in_valid      = 1'b1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(exp_t'{model(code, mode), (code >= 16), exp_tag});
      exp_tag = exp_tag + TAG_W'(1);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_ok(input int code, input bit mode);
    bit ok;
    send(code, mode, 20, ok);
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic set_ready(input bit r);
    @(posedge clk); #1;
    out_ready = r;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    set_ready(1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (!out_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    pon_rst_i = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    @(posedge clk); #1;
    pon_rst_i = 1'b0;
  endtask

  // Monitor: every head handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!pon_rst_i && !flush_i && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: tag %h data %h with empty scoreboard", out_tag, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_err", 32'(out_err), 32'(mon_e.err));
        chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
`ifdef DECODER_PIPE_PARITY_EN
        chk("out_par", 32'(out_par), 32'(^{mon_e.data, mon_e.err, mon_e.tag}));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ok;
    encoded_input = '0;
    mode_i        = 1'b0;
    in_valid      = 1'b0;
    flush_i       = 1'b0;
    out_ready     = 1'b0;

    #2 pon_rst_i = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 pon_rst_i = 1'b0;

    // One-hot code 5 and exact three-cycle latency.
    out_ready = 1'b1;
    send_ok(5, 1'b0);
    @(posedge clk); #2;
    chk("latency_early", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    chk("latency_on_time", 32'(out_valid), 32'd1);

    send_ok(3, 1'b1);
    send_ok(15, 1'b1);
    send_ok(0, 1'b1);
    send_ok(16, 1'b0);
    send_ok(200, 1'b1);
    drain();
    chk("err_count_two", 32'(err_count), 32'd2);

    for (int i = 0; i < 300; i++) send_ok(16 + (i % 240), i[0]);
    drain();
    chk("err_count_sat", 32'(err_count), 32'hFF);

    // Backpressure: only DEPTH entries get in.
    do_reset();
    set_ready(1'b0);
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      send(k, 1'b0, 8, ok);
      if (ok) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_tag", 32'(out_tag), 32'd0);
    drain();
    send_ok(9, 1'b0);
    drain();

    // Pop in the same cycle as a WRITE push with two queued.
    set_ready(1'b0);
    send_ok(1, 1'b0);
    send_ok(2, 1'b0);
    send_ok(4, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_push_count", 32'(u_dut.u_fifo.count_q), 32'd2);
    drain();

    // Flush while an entry is in DECODE with two queued.
    set_ready(1'b0);
    send_ok(6, 1'b0);
    send_ok(7, 1'b1);
    send_ok(8, 1'b0);
    flush_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("flush_empty", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("flush_no_push", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send_ok(11, 1'b0);
    drain();

    // Run the tag counter up to its wrap point.
    set_ready(1'b1);
    while (exp_tag != 13'h1FFF) send_ok(int'(exp_tag[3:0]), 1'b0);
    send_ok(12, 1'b1);
    send_ok(13, 1'b0);
    drain();

    // Asynchronous reset during WRITE with one entry queued.
    set_ready(1'b0);
    send_ok(3, 1'b0);
    send_ok(5, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    pon_rst_i = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_tag = '0;
    @(posedge clk); #1;
    pon_rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("arst_no_push", 32'(out_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
